// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin values, dispenser states, product codes.
// Used by coin_change_dispenser and the upstream controller.
package vm_pkg;

  localparam int COIN_HI_DEF = 5;
  localparam int COIN_LO_DEF = 1;

  // state    | meaning
  // IDLE     | waiting for a change request (product != 0)
  // DISPENSE | choose next coin or finish
  // GAP      | spacing cycle between coin pulses
  // DONE     | done pulse issued, clearing busy
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_GAP      = 2'd2,
    ST_DONE     = 2'd3
  } disp_state_t;

  localparam logic [3:0] PROD_NONE = 4'd0;
  localparam logic [3:0] PROD_A    = 4'd1;
  localparam logic [3:0] PROD_B    = 4'd2;
  localparam logic [3:0] PROD_C    = 4'd3;
  localparam logic [3:0] PROD_D    = 4'd4;

endpackage

// File: rtl/coin_inventory.sv
// One coin-denomination inventory: saturating up on refill, down on take.
// A simultaneous refill and take cancel out.
module coin_inventory #(
  parameter int INV_W    = 6,
  parameter int INV_INIT = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             refill,
  input  logic             take,
  output logic [INV_W-1:0] count
);

  localparam logic [INV_W-1:0] CNT_MAX  = '1;
  localparam logic [INV_W-1:0] CNT_INIT = INV_INIT[INV_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= CNT_INIT;
    end else if (refill && !take) begin
      if (count != CNT_MAX) count <= count + 1'b1;
    end else if (take && !refill) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/coin_change_dispenser.sv
// Pays out a change amount as spaced coin pulses from two inventories.
// Optional DISPENSER_AUDIT_EN adds a running total_paid counter.
module coin_change_dispenser
  import vm_pkg::*;
#(
  parameter int COIN_HI  = COIN_HI_DEF,
  parameter int COIN_LO  = COIN_LO_DEF,
  parameter int INV_W    = 6,
  parameter int INV_INIT = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       product,
  input  logic [3:0]       change,
  input  logic             refill_hi,
  input  logic             refill_lo,
  output logic             coin_hi,
  output logic             coin_lo,
  output logic             busy,
  output logic             done,
  output logic [3:0]       shortfall,
  output logic             overrun,
`ifdef DISPENSER_AUDIT_EN
  output logic [7:0]       total_paid,
`endif
  output logic [INV_W-1:0] hi_count,
  output logic [INV_W-1:0] lo_count
);

  localparam logic [3:0] HI_VAL = COIN_HI[3:0];
  localparam logic [3:0] LO_VAL = COIN_LO[3:0];

  disp_state_t state;
  logic [3:0]  remaining;
  logic        take_hi;
  logic        take_lo;

  // Coin selection is combinational so the inventory decrements on the same
  // edge that registers the pulse.
  always_comb begin
    take_hi = 1'b0;
    take_lo = 1'b0;
    if (state == ST_DISPENSE) begin
      if (remaining >= HI_VAL && hi_count != '0)      take_hi = 1'b1;
      else if (remaining >= LO_VAL && lo_count != '0) take_lo = 1'b1;
    end
  end

  coin_inventory #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv_hi (
    .clock  (clock),
    .reset  (reset),
    .refill (refill_hi),
    .take   (take_hi),
    .count  (hi_count)
  );

  coin_inventory #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv_lo (
    .clock  (clock),
    .reset  (reset),
    .refill (refill_lo),
    .take   (take_lo),
    .count  (lo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      coin_hi   <= 1'b0;
      coin_lo   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shortfall <= '0;
      overrun   <= 1'b0;
    end else begin
      coin_hi <= 1'b0;
      coin_lo <= 1'b0;
      done    <= 1'b0;
      if (product != PROD_NONE && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (product != PROD_NONE) begin
            remaining <= change;
            shortfall <= '0;
            busy      <= 1'b1;
            state     <= ST_DISPENSE;
          end
        end
        ST_DISPENSE: begin
          if (take_hi) begin
            coin_hi   <= 1'b1;
            remaining <= remaining - HI_VAL;
            state     <= ST_GAP;
          end else if (take_lo) begin
            coin_lo   <= 1'b1;
            remaining <= remaining - LO_VAL;
            state     <= ST_GAP;
          end else begin
            shortfall <= remaining;
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_GAP: state <= ST_DISPENSE;
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DISPENSER_AUDIT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        total_paid <= '0;
    else if (take_hi) total_paid <= total_paid + {4'd0, HI_VAL};
    else if (take_lo) total_paid <= total_paid + {4'd0, LO_VAL};
  end
`endif

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed self-checking bench for coin_change_dispenser (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_coin_change_dispenser;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] product = '0;
  logic [3:0] change = '0;
  logic       refill_hi = 1'b0;
  logic       refill_lo = 1'b0;
  logic       coin_hi, coin_lo, busy, done, overrun;
  logic [3:0] shortfall;
  logic [5:0] hi_count, lo_count;
`ifdef DISPENSER_AUDIT_EN
  logic [7:0] total_paid;
`endif

  int checks = 0;
  int errors = 0;

  coin_change_dispenser dut (
    .clock     (clock),
    .reset     (reset),
    .product   (product),
    .change    (change),
    .refill_hi (refill_hi),
    .refill_lo (refill_lo),
    .coin_hi   (coin_hi),
    .coin_lo   (coin_lo),
    .busy      (busy),
    .done      (done),
    .shortfall (shortfall),
    .overrun   (overrun),
`ifdef DISPENSER_AUDIT_EN
    .total_paid(total_paid),
`endif
    .hi_count  (hi_count),
    .lo_count  (lo_count)
  );

  always #5 clock = ~clock;

  // Issues one request at a falling edge and records the payout, edge by edge
  // after the capture edge. inj > 0 injects a second request sampled at that edge.
  task automatic run_payout(input logic [3:0] prod, input logic [3:0] chg, input int inj,
                            output int nhi, output int nlo, output int first_edge,
                            output int done_edge, output logic [3:0] sf, output int bad);
    logic prev;
    nhi = 0; nlo = 0; first_edge = -1; done_edge = -1; sf = 4'hx; bad = 0; prev = 1'b0;
    product = prod; change = chg;
    @(negedge clock);
    product = '0; change = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k == inj) begin product = 4'd2; change = 4'd9; end
      @(negedge clock);
      product = '0; change = '0;
      if (coin_hi && coin_lo) bad++;
      if ((coin_hi || coin_lo) && prev) bad++;
      prev = coin_hi || coin_lo;
      if (coin_hi) nhi++;
      if (coin_lo) nlo++;
      if ((coin_hi || coin_lo) && first_edge < 0) first_edge = k;
      if (done) begin done_edge = k; sf = shortfall; break; end
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({coin_hi, coin_lo, busy, done, overrun} !== 5'b0 || shortfall !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: got hi=%b lo=%b busy=%b done=%b ovr=%b sf=%0d, want all 0",
               coin_hi, coin_lo, busy, done, overrun, shortfall);
    end
    checks++;
    if (hi_count !== 6'd20 || lo_count !== 6'd20) begin
      errors++;
      $display("FAIL reset_counts: got hi=%0d lo=%0d, want 20/20", hi_count, lo_count);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_change7();
    int nhi, nlo, fe, de, bad; logic [3:0] sf;
    run_payout(4'd1, 4'd7, 0, nhi, nlo, fe, de, sf, bad);
    checks++;
    if (nhi !== 1 || nlo !== 2 || bad !== 0) begin
      errors++;
      $display("FAIL change7_coins: got hi=%0d lo=%0d bad=%0d, want 1/2/0", nhi, nlo, bad);
    end
    checks++;
    if (fe !== 1 || de !== 7 || sf !== 4'd0) begin
      errors++;
      $display("FAIL change7_timing: got first=%0d done=%0d sf=%0d, want 1/7/0", fe, de, sf);
    end
    checks++;
    if (hi_count !== 6'd19 || lo_count !== 6'd18 || busy !== 1'b0) begin
      errors++;
      $display("FAIL change7_counts: got hi=%0d lo=%0d busy=%b, want 19/18/0", hi_count, lo_count, busy);
    end
  endtask

  task automatic test_change0();
    int nhi, nlo, fe, de, bad; logic [3:0] sf;
    run_payout(4'd4, 4'd0, 0, nhi, nlo, fe, de, sf, bad);
    checks++;
    if (nhi !== 0 || nlo !== 0 || de !== 1 || sf !== 4'd0) begin
      errors++;
      $display("FAIL change0: got hi=%0d lo=%0d done=%0d sf=%0d, want 0/0/1/0", nhi, nlo, de, sf);
    end
    checks++;
    if (hi_count !== 6'd19 || lo_count !== 6'd18) begin
      errors++;
      $display("FAIL change0_counts: got hi=%0d lo=%0d, want 19/18", hi_count, lo_count);
    end
  endtask

  task automatic test_overrun();
    int nhi, nlo, fe, de, bad; logic [3:0] sf;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre: got %b, want 0", overrun);
    end
    run_payout(4'd1, 4'd7, 2, nhi, nlo, fe, de, sf, bad);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: got %b, want 1", overrun);
    end
    checks++;
    if (nhi !== 1 || nlo !== 2 || de !== 7 || sf !== 4'd0 || bad !== 0) begin
      errors++;
      $display("FAIL overrun_payout: got hi=%0d lo=%0d done=%0d sf=%0d bad=%0d, want 1/2/7/0/0",
               nhi, nlo, de, sf, bad);
    end
    checks++;
    if (hi_count !== 6'd18 || lo_count !== 6'd16) begin
      errors++;
      $display("FAIL overrun_counts: got hi=%0d lo=%0d, want 18/16", hi_count, lo_count);
    end
  endtask

  task automatic test_refill();
    int seen_done = 0;
    product = 4'd3; change = 4'd1;
    @(negedge clock);
    product = '0; change = '0; refill_lo = 1'b1;
    @(negedge clock);
    refill_lo = 1'b0;
    checks++;
    if (coin_lo !== 1'b1 || lo_count !== 6'd16) begin
      errors++;
      $display("FAIL refill_take: got coin_lo=%b lo=%0d, want 1/16", coin_lo, lo_count);
    end
    for (int k = 0; k < 10 && seen_done == 0; k++) begin
      @(negedge clock);
      if (done) seen_done = 1;
    end
    checks++;
    if (seen_done !== 1) begin
      errors++;
      $display("FAIL refill_done: got done_seen=%0d, want 1", seen_done);
    end
    @(negedge clock);
    refill_lo = 1'b1;
    @(negedge clock);
    refill_lo = 1'b0;
    checks++;
    if (lo_count !== 6'd17) begin
      errors++;
      $display("FAIL refill_lo_inc: got %0d, want 17", lo_count);
    end
    refill_hi = 1'b1;
    repeat (44) @(negedge clock);
    checks++;
    if (hi_count !== 6'd62) begin
      errors++;
      $display("FAIL refill_hi_count: got %0d, want 62", hi_count);
    end
    repeat (6) @(negedge clock);
    refill_hi = 1'b0;
    checks++;
    if (hi_count !== 6'd63) begin
      errors++;
      $display("FAIL refill_sat: got %0d, want 63", hi_count);
    end
  endtask

  task automatic test_reset_mid();
    int nhi, nlo, fe, de, bad; logic [3:0] sf;
    int pulses = 0;
    product = 4'd1; change = 4'd7;
    @(negedge clock);
    product = '0; change = '0;
    @(negedge clock);
    checks++;
    if (coin_hi !== 1'b1) begin
      errors++;
      $display("FAIL mid_first_coin: got coin_hi=%b, want 1", coin_hi);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || coin_hi !== 1'b0 || overrun !== 1'b0 || hi_count !== 6'd20 || lo_count !== 6'd20) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b coin_hi=%b ovr=%b hi=%0d lo=%0d, want 0/0/0/20/20",
               busy, coin_hi, overrun, hi_count, lo_count);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (coin_hi || coin_lo) pulses++;
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (coin_hi || coin_lo || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL mid_no_pulses: got %0d pulse/busy cycles, want 0", pulses);
    end
    run_payout(4'd2, 4'd6, 0, nhi, nlo, fe, de, sf, bad);
    checks++;
    if (nhi !== 1 || nlo !== 1 || de !== 5 || sf !== 4'd0 || hi_count !== 6'd19 || lo_count !== 6'd19) begin
      errors++;
      $display("FAIL mid_after: got hi=%0d lo=%0d done=%0d sf=%0d cnt=%0d/%0d, want 1/1/5/0/19/19",
               nhi, nlo, de, sf, hi_count, lo_count);
    end
  endtask

  task automatic test_shortfall();
    int nhi, nlo, fe, de, bad; logic [3:0] sf;
    logic [3:0] drain [5] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd2};
    for (int i = 0; i < 5; i++) begin
      run_payout(4'd1, drain[i], 0, nhi, nlo, fe, de, sf, bad);
      checks++;
      if (nhi !== 0 || nlo !== int'(drain[i]) || sf !== 4'd0) begin
        errors++;
        $display("FAIL drain_%0d: got hi=%0d lo=%0d sf=%0d, want 0/%0d/0", i, nhi, nlo, sf, drain[i]);
      end
    end
    checks++;
    if (lo_count !== 6'd1 || hi_count !== 6'd19) begin
      errors++;
      $display("FAIL drain_counts: got hi=%0d lo=%0d, want 19/1", hi_count, lo_count);
    end
    run_payout(4'd3, 4'd3, 0, nhi, nlo, fe, de, sf, bad);
    checks++;
    if (nhi !== 0 || nlo !== 1 || de !== 3 || sf !== 4'd2) begin
      errors++;
      $display("FAIL shortfall: got hi=%0d lo=%0d done=%0d sf=%0d, want 0/1/3/2", nhi, nlo, de, sf);
    end
    @(negedge clock);
    checks++;
    if (shortfall !== 4'd2 || lo_count !== 6'd0 || hi_count !== 6'd19 || busy !== 1'b0) begin
      errors++;
      $display("FAIL shortfall_hold: got sf=%0d lo=%0d hi=%0d busy=%b, want 2/0/19/0",
               shortfall, lo_count, hi_count, busy);
    end
  endtask

  initial begin
    test_reset();
    test_change7();
    test_change0();
    test_overrun();
    test_refill();
    test_reset_mid();
    test_shortfall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
